caf_sweep_ctrl: RTL
===================

CAF_SWEEP_CTRL -- requirements
Module: caf_sweep_ctrl

Interface
REQ-001 SHALL take parameter phase_bits, default 10: width of each frequency step word.
REQ-002 SHALL take parameter foas, default 3: number of frequency offsets per sweep.
REQ-003 SHALL take parameter length, default 5: number of samples per correlation.
REQ-004 SHALL take parameter out_max_bits, default 64: width of the correlation magnitude.
REQ-005 SHALL take parameter timeout_cycles, default 1024: result watchdog limit. Used only with CAF_SWEEP_CTRL_TIMEOUT_EN.
REQ-006 SHALL derive FW = $clog2(foas) and LW = $clog2(length), each with a minimum of 1.
REQ-007 clk  in  1  sole clock; all logic is rising-edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle sweep request; accepted only in IDLE.
REQ-010 base_step, delta_step  in  phase_bits each  first step, and the increment between steps.
REQ-011 neg_cfg  in  1  negative-shift flag applied to every step of the sweep.
REQ-012 threshold  in  out_max_bits  detection threshold.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 caf_step_valid / caf_step_ready  out / in  1  handshake for frequency steps.
REQ-015 caf_step  out  phase_bits  current frequency step.
REQ-016 caf_neg  out  1  negative-shift flag for the current step.
REQ-017 src_valid / src_ready  in / out  1  upstream sample handshake.
REQ-018 caf_smp_valid / caf_smp_ready  out / in  1  sample handshake toward the correlator.
REQ-019 res_valid / res_ready  in / out  1  correlator result handshake.
REQ-020 res_max, res_foas, res_time  in  out_max_bits, FW, LW  correlator result fields.
REQ-021 det_valid / det_ready  out / in  1  detection report handshake.
REQ-022 det_hit, det_max, det_foas, det_time  out  1, out_max_bits, FW, LW  registered detection report.
REQ-023 err_timeout  out  1  sticky watchdog error flag.

Function
REQ-024 SHALL implement states IDLE -> LOAD -> STREAM -> WAIT_RES -> REPORT -> IDLE.
REQ-025 IDLE & start SHALL capture base_step, delta_step, neg_cfg and threshold; SHALL clear the step counter k; next state is LOAD.
REQ-026 LOAD SHALL hold caf_step_valid=1, with caf_step = base + k*delta (modulo 2^phase_bits, wrapping) and caf_neg = captured neg_cfg.
REQ-027 In LOAD, each valid&ready cycle SHALL increment k; the handshake at k=foas-1 SHALL move the state to STREAM.
REQ-028 In LOAD, caf_step and caf_neg SHALL remain stable while caf_step_valid=1 and caf_step_ready=0.
REQ-029 STREAM SHALL set caf_smp_valid = src_valid and src_ready = caf_smp_ready combinationally; outside STREAM both SHALL be 0.
REQ-030 STREAM SHALL count sample handshakes; the length-th handshake SHALL move the state to WAIT_RES.
REQ-031 WAIT_RES SHALL drive res_ready=1; a res handshake SHALL register res_foas/res_time into det_foas/det_time, set det_max = res_max, set det_hit = (res_max >= threshold) unsigned, and move the state to REPORT.
REQ-032 REPORT SHALL hold det_valid=1 until det_ready; det_* SHALL be stable while det_valid=1 and det_ready=0; the det handshake SHALL move the state to IDLE.
REQ-033 Latency: the first caf_step_valid SHALL appear 1 cycle after start is accepted; det_valid SHALL rise 1 cycle after the res handshake.
REQ-034 start asserted outside IDLE SHALL be ignored.
REQ-035 A res_valid received outside WAIT_RES SHALL not be accepted (res_ready=0).

Reset
REQ-036 While rst=1: state=IDLE, k=0, sample count=0, and all outputs 0 (busy, caf_step_valid, caf_step, caf_neg, src_ready, caf_smp_valid, res_ready, det_valid, det_hit, det_max, det_foas, det_time, err_timeout).
REQ-037 rst asserted mid-sweep SHALL abort immediately; no partial report SHALL be emitted.

Configuration
REQ-038 With CAF_SWEEP_CTRL_TIMEOUT_EN defined: a WAIT_RES dwell of timeout_cycles cycles without a res handshake SHALL set err_timeout (sticky until rst), det_hit=0, det_max=0, and move the state to REPORT.
REQ-039 Without CAF_SWEEP_CTRL_TIMEOUT_EN: err_timeout SHALL be tied 0, no timeout counter SHALL exist, and WAIT_RES SHALL wait indefinitely.

Structure
REQ-040 Package caf_pkg SHALL hold the state enum (caf_sweep_state_t) and the default parameter constants.
REQ-041 The step generator (accumulator base + k*delta) SHALL be sub-module caf_step_gen.

Verification
REQ-042 foas=3, base=10, delta=7, caf_step_ready always 1 -> caf_step 10, 17, 24 in 3 consecutive cycles, then STREAM.
REQ-043 caf_step_ready=0 for 4 cycles at k=1 -> caf_step holds 17; the sweep then completes with 3 handshakes total.
REQ-044 Samples with src_valid toggling -> exactly 5 accepted, then src_ready=0; the 6th sample is not forwarded.
REQ-045 res_max=500, threshold=500 -> det_hit=1; res_max=499 -> det_hit=0; det_ready held low 3 cycles -> outputs stable.
REQ-046 Assert rst in STREAM -> all outputs 0 in the same cycle; the next start sweeps from k=0.
REQ-047 With CAF_SWEEP_CTRL_TIMEOUT_EN, timeout_cycles=16, no res_valid -> err_timeout=1 after 16 cycles in WAIT_RES, det_valid=1, det_hit=0.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared types and default sizing for the CAF sweep controller.
// Holds the sweep state enum and a clog2 helper clamped to 1 bit.
package caf_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    REPORT   = 3'd4
  } caf_sweep_state_t;

  localparam int CAF_PHASE_BITS     = 10;
  localparam int CAF_FOAS           = 3;
  localparam int CAF_LENGTH         = 5;
  localparam int CAF_OUT_MAX_BITS   = 64;
  localparam int CAF_TIMEOUT_CYCLES = 1024;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/caf_sweep_ctrl_if.sv
// Handshake and data bundle between the sweep controller and its
// environment (step sink, sample source/sink, result source, report sink).
interface caf_sweep_ctrl_if
  import caf_pkg::*;
#(
  parameter int phase_bits   = CAF_PHASE_BITS,
  parameter int out_max_bits = CAF_OUT_MAX_BITS,
  parameter int fw           = clog2_min1(CAF_FOAS),
  parameter int lw           = clog2_min1(CAF_LENGTH)
) ();

  logic                    start;
  logic [phase_bits-1:0]   base_step;
  logic [phase_bits-1:0]   delta_step;
  logic                    neg_cfg;
  logic [out_max_bits-1:0] threshold;
  logic                    busy;

  logic                    caf_step_valid;
  logic                    caf_step_ready;
  logic [phase_bits-1:0]   caf_step;
  logic                    caf_neg;

  logic                    src_valid;
  logic                    src_ready;
  logic                    caf_smp_valid;
  logic                    caf_smp_ready;

  logic                    res_valid;
  logic                    res_ready;
  logic [out_max_bits-1:0] res_max;
  logic [fw-1:0]           res_foas;
  logic [lw-1:0]           res_time;

  logic                    det_valid;
  logic                    det_ready;
  logic                    det_hit;
  logic [out_max_bits-1:0] det_max;
  logic [fw-1:0]           det_foas;
  logic [lw-1:0]           det_time;
  logic                    err_timeout;

  modport master (
    input  start, base_step, delta_step, neg_cfg, threshold,
    input  caf_step_ready, src_valid, caf_smp_ready,
    input  res_valid, res_max, res_foas, res_time, det_ready,
    output busy, caf_step_valid, caf_step, caf_neg,
    output src_ready, caf_smp_valid, res_ready,
    output det_valid, det_hit, det_max, det_foas, det_time,
    output err_timeout
  );

  modport slave (
    output start, base_step, delta_step, neg_cfg, threshold,
    output caf_step_ready, src_valid, caf_smp_ready,
    output res_valid, res_max, res_foas, res_time, det_ready,
    input  busy, caf_step_valid, caf_step, caf_neg,
    input  src_ready, caf_smp_valid, res_ready,
    input  det_valid, det_hit, det_max, det_foas, det_time,
    input  err_timeout
  );

endinterface

// File: rtl/caf_step_gen.sv
// Frequency step accumulator: step = base + k*delta, wrapping modulo
// 2^phase_bits, advanced once per accepted step.
module caf_step_gen
  import caf_pkg::*;
#(
  parameter int phase_bits = CAF_PHASE_BITS,
  parameter int foas       = CAF_FOAS,
  parameter int fw         = clog2_min1(CAF_FOAS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  input  logic [phase_bits-1:0] base,
  input  logic [phase_bits-1:0] delta,
  output logic [phase_bits-1:0] step,
  output logic                  last
);

  logic [phase_bits-1:0] acc;
  logic [phase_bits-1:0] dlt;
  logic [fw-1:0]         k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      dlt <= '0;
      k   <= '0;
    end else if (load) begin
      acc <= base;
      dlt <= delta;
      k   <= '0;
    end else if (adv) begin
      acc <= acc + dlt;
      k   <= k + 1'b1;
    end
  end

  assign step = acc;
  assign last = (k == fw'(foas - 1));

endmodule

// File: rtl/caf_sweep_ctrl.sv
// CAF sweep controller: loads foas steps, streams length samples, then
// reports the thresholded result. CAF_SWEEP_CTRL_TIMEOUT_EN adds a watchdog.
module caf_sweep_ctrl
  import caf_pkg::*;
#(
  parameter int phase_bits     = CAF_PHASE_BITS,
  parameter int foas           = CAF_FOAS,
  parameter int length         = CAF_LENGTH,
  parameter int out_max_bits   = CAF_OUT_MAX_BITS,
  parameter int timeout_cycles = CAF_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  caf_sweep_ctrl_if.master bus
);

  localparam int FW = clog2_min1(foas);
  localparam int LW = clog2_min1(length);

  caf_sweep_state_t state, state_nxt;

  logic                    neg_q;
  logic [out_max_bits-1:0] thr_q;
  logic [LW-1:0]           scnt;
  logic [phase_bits-1:0]   step;
  logic                    step_last;
  logic                    start_ok;
  logic                    step_hs;
  logic                    smp_hs;
  logic                    smp_last;
  logic                    res_hs;
  logic                    det_hs;
  logic                    to_hit;

  logic                    det_hit_q;
  logic [out_max_bits-1:0] det_max_q;
  logic [FW-1:0]           det_foas_q;
  logic [LW-1:0]           det_time_q;

  assign start_ok = (state == IDLE) && bus.start;
  assign step_hs  = (state == LOAD) && bus.caf_step_ready;
  assign smp_hs   = (state == STREAM) && bus.src_valid
                    && bus.caf_smp_ready;
  assign smp_last = (scnt == LW'(length - 1));
  assign res_hs   = (state == WAIT_RES) && bus.res_valid;
  assign det_hs   = (state == REPORT) && bus.det_ready;

  caf_step_gen #(
    .phase_bits (phase_bits),
    .foas       (foas),
    .fw         (FW)
  ) u_step_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .adv   (step_hs),
    .base  (bus.base_step),
    .delta (bus.delta_step),
    .step  (step),
    .last  (step_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.busy           = (state != IDLE);
    bus.caf_step_valid = 1'b0;
    bus.caf_step       = '0;
    bus.caf_neg        = 1'b0;
    bus.caf_smp_valid  = 1'b0;
    bus.src_ready      = 1'b0;
    bus.res_ready      = 1'b0;
    bus.det_valid      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        bus.caf_step_valid = 1'b1;
        bus.caf_step       = step;
        bus.caf_neg        = neg_q;
        if (step_hs && step_last) state_nxt = STREAM;
      end
      STREAM: begin
        bus.caf_smp_valid = bus.src_valid;
        bus.src_ready     = bus.caf_smp_ready;
        if (smp_hs && smp_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        bus.res_ready = 1'b1;
        if (res_hs || to_hit) state_nxt = REPORT;
      end
      REPORT: begin
        bus.det_valid = 1'b1;
        if (det_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q      <= 1'b0;
      thr_q      <= '0;
      scnt       <= '0;
      det_hit_q  <= 1'b0;
      det_max_q  <= '0;
      det_foas_q <= '0;
      det_time_q <= '0;
    end else begin
      if (start_ok) begin
        neg_q <= bus.neg_cfg;
        thr_q <= bus.threshold;
      end
      if (smp_hs) scnt <= smp_last ? '0 : scnt + 1'b1;
      if (res_hs) begin
        det_hit_q  <= (bus.res_max >= thr_q);
        det_max_q  <= bus.res_max;
        det_foas_q <= bus.res_foas;
        det_time_q <= bus.res_time;
      end else if (to_hit) begin
        det_hit_q <= 1'b0;
        det_max_q <= '0;
      end
    end
  end

`ifdef CAF_SWEEP_CTRL_TIMEOUT_EN
  localparam int TW = clog2_min1(timeout_cycles);

  logic [TW-1:0] tcnt;
  logic          err_q;

  // Dwell counter restarts on every entry to WAIT_RES.
  assign to_hit = (state == WAIT_RES) && !bus.res_valid
                  && (tcnt == TW'(timeout_cycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (state == WAIT_RES) ? tcnt + 1'b1 : '0;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign to_hit          = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.det_hit  = det_hit_q;
  assign bus.det_max  = det_max_q;
  assign bus.det_foas = det_foas_q;
  assign bus.det_time = det_time_q;

endmodule
